// File: rtl/intel_vvp_demosaic_pkg.sv
// Shared types, Bayer pattern constants and stream width helpers for the demosaic stage.
package intel_vvp_demosaic_pkg;

  typedef enum logic [1:0] {
    BLUE     = 2'b00,
    GREEN    = 2'b01,
    RED      = 2'b10,
    BLUE_ALT = 2'b11
  } colour_code_t;

  // Codes packed as {c00, c01, c10, c11} indexed by (row parity, column parity)
  localparam logic [7:0] PATTERN_RGGB = 8'b10010100;
  localparam logic [7:0] PATTERN_BGGR = 8'b00010110;
  localparam logic [7:0] PATTERN_GRBG = 8'b01100001;
  localparam logic [7:0] PATTERN_GBRG = 8'b01001001;

  function automatic int ceil8(input int bits);
    return ((bits + 7) / 8) * 8;
  endfunction

  function automatic int padded_bps(input int bps);
    return (bps > 8) ? bps : 8;
  endfunction

  function automatic int in_pix_bits(input int bps);
    return ceil8(padded_bps(bps));
  endfunction

  function automatic int out_pix_bits(input int bps);
    return ceil8(3 * padded_bps(bps));
  endfunction

  function automatic int in_tuser_bits(input int bps, input int pip);
    return pip * in_pix_bits(bps) / 8;
  endfunction

  function automatic int out_tuser_bits(input int bps, input int pip);
    return pip * out_pix_bits(bps) / 8;
  endfunction

  function automatic colour_code_t code_at(input logic [7:0] mode, input logic row_odd,
                                           input logic col_odd);
    logic [1:0] sel;
    case ({row_odd, col_odd})
      2'b00:   sel = mode[7:6];
      2'b01:   sel = mode[5:4];
      2'b10:   sel = mode[3:2];
      default: sel = mode[1:0];
    endcase
    return colour_code_t'(sel);
  endfunction

endpackage

// File: rtl/intel_vvp_demosaic_if.sv
// AXI4-Stream video bundle (data, last, user, valid/ready) used on both sides of the demosaic.
interface intel_vvp_demosaic_if
  import intel_vvp_demosaic_pkg::*;
#(
  parameter int DATA_W = 2 * in_pix_bits(10),
  parameter int USER_W = in_tuser_bits(10, 2)
);
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/intel_vvp_demosaic_line_buf.sv
// Simple dual-port line buffer holding one previous-row beat per address, 1-cycle registered read.
module intel_vvp_demosaic_line_buf #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             main_clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge main_clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;
endmodule

// File: rtl/intel_vvp_demosaic_gen.sv
// Bayer-to-BGR demosaic over a 2x2 window with a 1-beat output skid.
// Optional raw pass-through selected by INTEL_VVP_DEMOSAIC_BYPASS_EN (adds r_vid_bypass).
module intel_vvp_demosaic_gen
  import intel_vvp_demosaic_pkg::*;
#(
  parameter int         C_USE_CPU          = 1,
  parameter int         PIXELS_IN_PARALLEL = 2,
  parameter int         BPS                = 10,
  parameter int         C_MAX_WIDTH        = 4096,
  parameter logic [7:0] C_CONV_MODE        = PATTERN_BGGR
) (
  input  logic                  main_clock,
  input  logic                  main_reset,
  intel_vvp_demosaic_if.slave   axi4s_vid_in,
  intel_vvp_demosaic_if.master  axi4s_vid_out,
  input  logic [7:0]            r_vid_conv_mode
`ifdef INTEL_VVP_DEMOSAIC_BYPASS_EN
  , input  logic                r_vid_bypass
`endif
);
  localparam int PIP       = PIXELS_IN_PARALLEL;
  localparam int PBPS      = padded_bps(BPS);
  localparam int IN_PIX_W  = in_pix_bits(BPS);
  localparam int OUT_PIX_W = out_pix_bits(BPS);
  localparam int OUT_W     = PIP * OUT_PIX_W;
  localparam int ROW_W     = PIP * PBPS;
  localparam int DEPTH     = C_MAX_WIDTH / PIP;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W     = $clog2(C_MAX_WIDTH) + 2;
  localparam int PIP_SH    = $clog2(PIP);
  localparam logic [COL_W-1:0] MAX_COL = COL_W'(C_MAX_WIDTH);

  logic             in_ready_reg, out_valid_reg, out_last_reg, out_sof_reg;
  logic [OUT_W-1:0] out_data_reg, skid_data_reg;
  logic             skid_valid_reg, skid_last_reg, skid_sof_reg;
  logic             row_reg, row_nz_reg, row_next, row_nz_next;
  logic [COL_W-1:0] col_reg, col_next, col_eff;
  logic [7:0]       mode_reg, mode_in, mode_eff;
  logic [PBPS-1:0]  left_reg, upleft_reg;
  logic             fwd_reg;
  logic [ROW_W-1:0] fwd_data_reg, ram_q, up_row, wr_data;
  logic [OUT_W-1:0] beat_data;
  logic             accept, sof_in, row_eff, row_nz_eff, up_valid, wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             bypass_eff;
  logic             unused_in_bits;

  assign accept     = axi4s_vid_in.tvalid & in_ready_reg;
  assign sof_in     = axi4s_vid_in.tuser[0];
  assign mode_in    = (C_USE_CPU != 0) ? r_vid_conv_mode : C_CONV_MODE;
  // An SOF beat already decodes as row 0 / column 0 with the freshly latched pattern
  assign mode_eff   = sof_in ? mode_in : mode_reg;
  assign row_eff    = sof_in ? 1'b0 : row_reg;
  assign row_nz_eff = sof_in ? 1'b0 : row_nz_reg;
  assign col_eff    = sof_in ? '0 : col_reg;
  assign up_valid   = row_nz_eff && (col_eff < MAX_COL);
  assign up_row     = fwd_reg ? fwd_data_reg : ram_q;
  assign unused_in_bits = ^{axi4s_vid_in.tuser, axi4s_vid_in.tdata, r_vid_conv_mode};

`ifdef INTEL_VVP_DEMOSAIC_BYPASS_EN
  logic bypass_reg;
  assign bypass_eff = sof_in ? r_vid_bypass : bypass_reg;
`else
  assign bypass_eff = 1'b0;
`endif

  always_comb begin
    col_next    = col_reg;
    row_next    = row_reg;
    row_nz_next = row_nz_reg;
    if (accept) begin
      if (axi4s_vid_in.tlast) begin
        col_next    = '0;
        row_next    = ~row_eff;
        row_nz_next = 1'b1;
      end else begin
        col_next    = (col_eff >= MAX_COL) ? col_eff : col_eff + COL_W'(PIP);
        row_next    = row_eff;
        row_nz_next = row_nz_eff;
      end
    end
  end

  // Read address tracks the beat expected next so the previous row is ready on arrival
  assign rd_addr = AW'(col_next >> PIP_SH);
  assign wr_addr = AW'(col_eff >> PIP_SH);
  assign wr_en   = accept && (col_eff < MAX_COL);

  intel_vvp_demosaic_line_buf #(.WIDTH(ROW_W), .DEPTH(DEPTH), .AW(AW)) u_line_buf (
    .main_clock (main_clock),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (ram_q)
  );

  for (genvar gi = 0; gi < PIP; gi++) begin : g_pix
    logic [PBPS-1:0]      cur_px, up_px, left_px, ul_px, r_val, b_val, g_a, g_b, g_val;
    logic [PBPS:0]        g_sum;
    logic [1:0]           g_cnt;
    logic                 left_pres, cpar;
    logic [PBPS-1:0]      smp  [4];
    logic                 pres [4];
    colour_code_t         code [4];
    logic [OUT_PIX_W-1:0] px_word;

    assign cur_px = axi4s_vid_in.tdata[gi*IN_PIX_W +: PBPS];
    assign up_px  = up_row[gi*PBPS +: PBPS];
    assign cpar   = col_eff[0] ^ 1'(gi % 2);
    assign wr_data[gi*PBPS +: PBPS] = cur_px;

    if (gi == 0) begin : g_edge
      assign left_px   = left_reg;
      assign ul_px     = upleft_reg;
      assign left_pres = (col_eff != '0);
    end else begin : g_inner
      assign left_px   = axi4s_vid_in.tdata[(gi-1)*IN_PIX_W +: PBPS];
      assign ul_px     = up_row[(gi-1)*PBPS +: PBPS];
      assign left_pres = 1'b1;
    end

    always_comb begin
      smp[0]  = cur_px;   smp[1]  = left_px;   smp[2]  = up_px;    smp[3]  = ul_px;
      pres[0] = 1'b1;     pres[1] = left_pres; pres[2] = up_valid; pres[3] = up_valid & left_pres;
      code[0] = code_at(mode_eff, row_eff, cpar);
      code[1] = code_at(mode_eff, row_eff, ~cpar);
      code[2] = code_at(mode_eff, ~row_eff, cpar);
      code[3] = code_at(mode_eff, ~row_eff, ~cpar);
      r_val = '0;
      b_val = '0;
      g_a   = '0;
      g_b   = '0;
      g_cnt = '0;
      // Scan lowest priority first so the current sample wins ties
      for (int j = 3; j >= 0; j--) begin
        if (pres[j] && code[j] == RED) r_val = smp[j];
        if (pres[j] && (code[j] == BLUE || code[j] == BLUE_ALT)) b_val = smp[j];
      end
      for (int j = 0; j < 4; j++) begin
        if (pres[j] && code[j] == GREEN) begin
          if (g_cnt == 2'd0) g_a = smp[j];
          else if (g_cnt == 2'd1) g_b = smp[j];
          if (g_cnt < 2'd2) g_cnt = g_cnt + 2'd1;
        end
      end
      g_sum = {1'b0, g_a} + {1'b0, g_b};
      case (g_cnt)
        2'd0:    g_val = '0;
        2'd1:    g_val = g_a;
        default: g_val = g_sum[PBPS:1];
      endcase
      px_word = OUT_PIX_W'({r_val, g_val, b_val});
      if (bypass_eff) px_word = OUT_PIX_W'({cur_px, cur_px, cur_px});
    end

    assign beat_data[gi*OUT_PIX_W +: OUT_PIX_W] = px_word;
  end

  always_ff @(posedge main_clock or posedge main_reset) begin
    if (main_reset) begin
      row_reg      <= 1'b0;
      row_nz_reg   <= 1'b0;
      col_reg      <= '0;
      mode_reg     <= C_CONV_MODE;
      left_reg     <= '0;
      upleft_reg   <= '0;
      fwd_reg      <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      row_reg    <= row_next;
      row_nz_reg <= row_nz_next;
      col_reg    <= col_next;
      // A one-beat line reads the address being written this cycle
      fwd_reg      <= wr_en && (wr_addr == rd_addr);
      fwd_data_reg <= wr_data;
      if (accept) begin
        left_reg   <= wr_data[(PIP-1)*PBPS +: PBPS];
        upleft_reg <= up_row[(PIP-1)*PBPS +: PBPS];
        if (sof_in) mode_reg <= mode_in;
      end
    end
  end

`ifdef INTEL_VVP_DEMOSAIC_BYPASS_EN
  always_ff @(posedge main_clock or posedge main_reset) begin
    if (main_reset) bypass_reg <= 1'b0;
    else if (accept && sof_in) bypass_reg <= r_vid_bypass;
  end
`endif

  always_ff @(posedge main_clock or posedge main_reset) begin
    if (main_reset) begin
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_sof_reg    <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_sof_reg   <= 1'b0;
    end else if (axi4s_vid_out.tready || !out_valid_reg) begin
      if (skid_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= skid_data_reg;
        out_last_reg   <= skid_last_reg;
        out_sof_reg    <= skid_sof_reg;
        skid_valid_reg <= 1'b0;
        in_ready_reg   <= 1'b1;
      end else begin
        out_valid_reg <= accept;
        if (accept) begin
          out_data_reg <= beat_data;
          out_last_reg <= axi4s_vid_in.tlast;
          out_sof_reg  <= sof_in;
        end
      end
    end else if (accept) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= beat_data;
      skid_last_reg  <= axi4s_vid_in.tlast;
      skid_sof_reg   <= sof_in;
      in_ready_reg   <= 1'b0;
    end
  end

  assign axi4s_vid_in.tready  = in_ready_reg;
  assign axi4s_vid_out.tvalid = out_valid_reg;
  assign axi4s_vid_out.tdata  = out_data_reg;
  assign axi4s_vid_out.tlast  = out_last_reg;
  assign axi4s_vid_out.tuser  = $bits(axi4s_vid_out.tuser)'(out_sof_reg);
endmodule

// File: tb/tb_intel_vvp_demosaic_gen.sv
// Directed bench for the demosaic stage: reset, BGGR/RGGB frames, stall, SOF mid-line, reset mid-frame.
module tb_intel_vvp_demosaic_gen;
  import intel_vvp_demosaic_pkg::*;

  logic       main_clock = 1'b0;
  logic       main_reset;
  logic [7:0] r_vid_conv_mode;
`ifdef INTEL_VVP_DEMOSAIC_BYPASS_EN
  logic       r_vid_bypass;
`endif

  intel_vvp_demosaic_if #(.DATA_W(32), .USER_W(4)) axi4s_vid_in ();
  intel_vvp_demosaic_if #(.DATA_W(64), .USER_W(8)) axi4s_vid_out ();

  intel_vvp_demosaic_gen #(
    .C_USE_CPU(1), .PIXELS_IN_PARALLEL(2), .BPS(10), .C_MAX_WIDTH(4096), .C_CONV_MODE(PATTERN_BGGR)
  ) dut (
    .main_clock      (main_clock),
    .main_reset      (main_reset),
    .axi4s_vid_in    (axi4s_vid_in),
    .axi4s_vid_out   (axi4s_vid_out),
    .r_vid_conv_mode (r_vid_conv_mode)
`ifdef INTEL_VVP_DEMOSAIC_BYPASS_EN
    , .r_vid_bypass  (r_vid_bypass)
`endif
  );

  always #5 main_clock = ~main_clock;

  int checks = 0;
  int errors = 0;
  int ready_low_cnt = 0;
  logic [63:0] rx_data [$];
  logic        rx_last [$];
  logic [7:0]  rx_user [$];
  logic [63:0] exp_bggr [4];
  logic [63:0] exp_rggb [4];

  always @(negedge main_clock) begin
    if (!main_reset && axi4s_vid_out.tvalid && axi4s_vid_out.tready) begin
      rx_data.push_back(axi4s_vid_out.tdata);
      rx_last.push_back(axi4s_vid_out.tlast);
      rx_user.push_back(axi4s_vid_out.tuser);
      $display("rx beat %0d data=%h last=%0d user=%h", rx_data.size() - 1,
               axi4s_vid_out.tdata, axi4s_vid_out.tlast, axi4s_vid_out.tuser);
    end
    if (!main_reset && !axi4s_vid_in.tready) ready_low_cnt++;
  end

  function automatic logic [31:0] px(input int b, input int g, input int r);
    return {2'b00, 10'(r), 10'(g), 10'(b)};
  endfunction

  function automatic logic [31:0] inb(input int p0, input int p1);
    return {16'(p1), 16'(p0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic rx_clear();
    rx_data.delete();
    rx_last.delete();
    rx_user.delete();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic sof);
    int waited = 0;
    axi4s_vid_in.tdata  = d;
    axi4s_vid_in.tlast  = last;
    axi4s_vid_in.tuser  = {3'b000, sof};
    axi4s_vid_in.tvalid = 1'b1;
    @(negedge main_clock);
    while (!axi4s_vid_in.tready && waited < 50) begin
      waited++;
      @(negedge main_clock);
    end
    check("send_timeout", 64'(waited < 50), 64'd1);
    @(posedge main_clock);
    #1;
    axi4s_vid_in.tvalid = 1'b0;
    axi4s_vid_in.tlast  = 1'b0;
    axi4s_vid_in.tuser  = '0;
  endtask

  task automatic send_std_frame(input logic [7:0] mode_after_sof);
    send_beat(inb(100, 200), 1'b0, 1'b1);
    r_vid_conv_mode = mode_after_sof;
    send_beat(inb(100, 200), 1'b1, 1'b0);
    send_beat(inb(300, 400), 1'b0, 1'b0);
    send_beat(inb(300, 400), 1'b1, 1'b0);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int cyc = 0;
    while (rx_data.size() < n && cyc < 100) begin
      @(posedge main_clock);
      cyc++;
    end
    repeat (3) @(posedge main_clock);
    #1;
    check({tag, "_count"}, 64'(rx_data.size()), 64'(n));
  endtask

  task automatic check_beat(input int idx, input logic [63:0] exp_d, input logic exp_last,
                            input logic exp_sof, input string tag);
    logic [63:0] d;
    logic        l;
    logic [7:0]  u;
    if (idx < rx_data.size()) begin
      d = rx_data[idx];
      l = rx_last[idx];
      u = rx_user[idx];
    end else begin
      d = 'x;
      l = 1'bx;
      u = 'x;
    end
    check({tag, "_data"}, d, exp_d);
    check({tag, "_last"}, 64'(l), 64'(exp_last));
    check({tag, "_user"}, 64'(u), {63'd0, exp_sof});
  endtask

  task automatic check_frame(input logic [63:0] e [4], input string tag);
    check_beat(0, e[0], 1'b0, 1'b1, {tag, "_b1"});
    check_beat(1, e[1], 1'b1, 1'b0, {tag, "_b2"});
    check_beat(2, e[2], 1'b0, 1'b0, {tag, "_b3"});
    check_beat(3, e[3], 1'b1, 1'b0, {tag, "_b4"});
  endtask

  initial begin
    exp_bggr[0] = {px(100, 200, 0),   px(100, 0, 0)};
    exp_bggr[1] = {px(100, 200, 0),   px(100, 200, 0)};
    exp_bggr[2] = {px(100, 250, 400), px(100, 300, 0)};
    exp_bggr[3] = {px(100, 250, 400), px(100, 250, 400)};
    exp_rggb[0] = {px(0, 200, 100),   px(0, 0, 100)};
    exp_rggb[1] = {px(0, 200, 100),   px(0, 200, 100)};
    exp_rggb[2] = {px(400, 250, 100), px(0, 300, 100)};
    exp_rggb[3] = {px(400, 250, 100), px(400, 250, 100)};

    main_reset             = 1'b1;
    r_vid_conv_mode        = PATTERN_BGGR;
    axi4s_vid_in.tdata     = '0;
    axi4s_vid_in.tlast     = 1'b0;
    axi4s_vid_in.tuser     = '0;
    axi4s_vid_in.tvalid    = 1'b0;
    axi4s_vid_out.tready   = 1'b1;
`ifdef INTEL_VVP_DEMOSAIC_BYPASS_EN
    r_vid_bypass           = 1'b0;
`endif
    repeat (3) @(posedge main_clock);
    #1;
    check("rst_tvalid", 64'(axi4s_vid_out.tvalid), 64'd0);
    check("rst_tdata",  axi4s_vid_out.tdata, 64'd0);
    check("rst_tlast",  64'(axi4s_vid_out.tlast), 64'd0);
    check("rst_tuser",  64'(axi4s_vid_out.tuser), 64'd0);
    check("rst_tready", 64'(axi4s_vid_in.tready), 64'd1);
    main_reset = 1'b0;
    @(posedge main_clock);
    #1;

    // Plain BGGR frame
    rx_clear();
    send_std_frame(PATTERN_BGGR);
    wait_rx(4, "bggr");
    check_frame(exp_bggr, "bggr");

    // Same frame with the output stalled for 5 cycles after the first beat
    rx_clear();
    ready_low_cnt = 0;
    fork
      send_std_frame(PATTERN_BGGR);
      begin
        @(posedge main_clock);
        #1;
        axi4s_vid_out.tready = 1'b0;
        repeat (5) @(posedge main_clock);
        #1;
        axi4s_vid_out.tready = 1'b1;
      end
    join
    wait_rx(4, "stall");
    check_frame(exp_bggr, "stall");
    check("stall_ready_low_max", 64'(ready_low_cnt <= 5), 64'd1);
    check("stall_ready_low_seen", 64'(ready_low_cnt > 0), 64'd1);

    // Pattern register switched to RGGB after the SOF: applies only from the next frame
    rx_clear();
    send_std_frame(PATTERN_RGGB);
    wait_rx(4, "mode_cur");
    check_frame(exp_bggr, "mode_cur");
    rx_clear();
    send_std_frame(PATTERN_RGGB);
    wait_rx(4, "mode_next");
    check_frame(exp_rggb, "mode_next");

    // SOF arriving in the middle of the third line
    r_vid_conv_mode = PATTERN_BGGR;
    rx_clear();
    send_beat(inb(100, 200), 1'b0, 1'b1);
    send_beat(inb(100, 200), 1'b1, 1'b0);
    send_beat(inb(300, 400), 1'b0, 1'b0);
    send_beat(inb(300, 400), 1'b1, 1'b0);
    send_beat(inb(100, 200), 1'b0, 1'b0);
    send_beat(inb(16'h111, 16'h222), 1'b0, 1'b1);
    send_beat(inb(16'h111, 16'h222), 1'b1, 1'b0);
    wait_rx(7, "midsof");
    check_beat(4, {px(100, 250, 400), px(100, 300, 0)}, 1'b0, 1'b0, "row2_b1");
    check_beat(5, {px(16'h111, 16'h222, 0), px(16'h111, 0, 0)}, 1'b0, 1'b1, "midsof_b1");
    check_beat(6, {px(16'h111, 16'h222, 0), px(16'h111, 16'h222, 0)}, 1'b1, 1'b0, "midsof_b2");

    // Asynchronous reset while a beat sits in the output register
    rx_clear();
    send_beat(inb(100, 200), 1'b0, 1'b1);
    main_reset = 1'b1;
    #2;
    check("midrst_tvalid", 64'(axi4s_vid_out.tvalid), 64'd0);
    check("midrst_tdata",  axi4s_vid_out.tdata, 64'd0);
    check("midrst_tlast",  64'(axi4s_vid_out.tlast), 64'd0);
    check("midrst_tuser",  64'(axi4s_vid_out.tuser), 64'd0);
    check("midrst_tready", 64'(axi4s_vid_in.tready), 64'd1);
    @(posedge main_clock);
    #1;
    main_reset = 1'b0;
    @(posedge main_clock);
    #1;
    rx_clear();
    send_std_frame(PATTERN_BGGR);
    wait_rx(4, "postrst");
    check_frame(exp_bggr, "postrst");

`ifdef INTEL_VVP_DEMOSAIC_BYPASS_EN
    rx_clear();
    r_vid_bypass = 1'b1;
    send_beat(inb(16'h155, 16'h155), 1'b1, 1'b1);
    wait_rx(1, "bypass");
    check_beat(0, {px(16'h155, 16'h155, 16'h155), px(16'h155, 16'h155, 16'h155)},
               1'b1, 1'b1, "bypass");
    r_vid_bypass = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
